// File: rtl/seq_det_scheduler.sv
// Round-robin time-multiplexed "1011" overlapping Mealy detector shared by N_CH serial channels.
// Optional per-channel saturating match counters are enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_scheduler #(
    parameter int N_CH  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   ch_valid,
    input  logic [N_CH-1:0]   ch_bit,
    output logic [N_CH-1:0]   ch_ready,
    input  logic              clr_en,
    input  logic [ID_W-1:0]   clr_id,
    output logic              match_valid,
    output logic [ID_W-1:0]   match_id,
    output logic              busy
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] match_cnt
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle
        S1 = 2'd1,  // seen "1"
        S2 = 2'd2,  // seen "10"
        S3 = 2'd3   // seen "101"
    } det_state_e;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_CH - 1);

    if (N_CH < 2 || N_CH > 16 || ID_W != $clog2(N_CH) || CNT_W < 1) begin : g_bad_cfg
        $error("seq_det_scheduler: unsupported N_CH/ID_W/CNT_W combination");
    end

    det_state_e        ctx [N_CH];
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   arb_idx;
    logic              grant_any;
    logic [N_CH-1:0]   clr_mask;
    logic [N_CH-1:0]   eligible;
    det_state_e        cur_state;
    det_state_e        nxt_state;
    logic              cur_bit;
    logic              hit;

    // A clear excludes its channel from arbitration, so clear always wins over an update.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        clr_mask = '0;
        if (clr_en && (int'(clr_id) < N_CH)) begin
            clr_mask[clr_id] = 1'b1;
        end
        eligible = ch_valid & ~clr_mask;
    end

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        arb_idx   = last_grant;
        ch_ready  = '0;
        for (int k = 0; k < N_CH; k++) begin
            arb_idx = (arb_idx == LAST_ID) ? '0 : arb_idx + ID_W'(1);
            if (!grant_any && eligible[arb_idx]) begin
                grant_any = 1'b1;
                grant_id  = arb_idx;
            end
        end
        if (grant_any) begin
            ch_ready[grant_id] = 1'b1;
        end
    end

    // Shared detector step: read the granted context, advance by one bit.
    always_comb begin
        cur_state = ctx[grant_id];
        cur_bit   = ch_bit[grant_id];
        nxt_state = cur_state;
        hit       = 1'b0;
        case (cur_state)
            S0: nxt_state = cur_bit ? S1 : S0;
            S1: nxt_state = cur_bit ? S1 : S2;
            S2: nxt_state = cur_bit ? S3 : S0;
            S3: begin
                nxt_state = cur_bit ? S1 : S2;
                hit       = cur_bit;
            end
            default: nxt_state = S0;
        endcase
    end

    // NOTE: the context store is a small register array, so it takes the asynchronous reset
    // like any other state; it must not be mapped to a RAM that cannot be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                ctx[i] <= S0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr_mask[i]) begin
                    ctx[i] <= S0;
                end else if (grant_any && (grant_id == ID_W'(i))) begin
                    ctx[i] <= nxt_state;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= LAST_ID;
            match_valid <= 1'b0;
            match_id    <= '0;
            busy        <= 1'b0;
        end else begin
            busy        <= grant_any;
            match_valid <= grant_any & hit;
            if (grant_any) begin
                last_grant <= grant_id;
            end
            if (grant_any && hit) begin
                match_id <= grant_id;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr_mask[i]) begin
                    cnt[i] <= '0;
                end else if (grant_any && hit && (grant_id == ID_W'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            match_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler: a history-based model predicts grants and match pulses,
// and a monitor process compares every registered output edge against the queued expectations.
module tb_seq_det_scheduler;

    localparam int N_CH  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 8;

    typedef struct {
        int edge_no;
        int id;
    } exp_match_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH-1:0]   ch_valid;
    logic [N_CH-1:0]   ch_bit;
    logic [N_CH-1:0]   ch_ready;
    logic              clr_en;
    logic [ID_W-1:0]   clr_id;
    logic              match_valid;
    logic [ID_W-1:0]   match_id;
    logic              busy;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [N_CH*CNT_W-1:0] match_cnt;
    logic [N_CH*CNT_W-1:0] cnt_exp;
    int                    cnt_m [N_CH];
`endif

    seq_det_scheduler #(.N_CH(N_CH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_ready    (ch_ready),
        .clr_en      (clr_en),
        .clr_id      (clr_id),
        .match_valid (match_valid),
        .match_id    (match_id),
        .busy        (busy)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each channel's accepted bits since its last clear/reset.
    int          hist_len [N_CH];
    logic [3:0]  hist     [N_CH];
    int          last_g;
    exp_match_t  sb [$];
    logic        busy_exp;
    int          last_id;
    logic        exp_hit;
    logic        mon_en;
    int          edge_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            hist_len[i] = 0;
            hist[i]     = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
            cnt_m[i]    = 0;
`endif
        end
        last_g   = N_CH - 1;
        sb.delete();
        busy_exp = 1'b0;
        last_id  = 0;
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_exp  = '0;
`endif
    endtask

    // Drives one cycle of stimulus, checks the combinational grant, and queues expectations.
    task automatic drive(input logic [N_CH-1:0] v, input logic [N_CH-1:0] b,
                         input logic ce, input int cid, output int g);
        logic [N_CH-1:0] elig;
        logic [N_CH-1:0] exp_ready;
        @(negedge clk);
        ch_valid = v;
        ch_bit   = b;
        clr_en   = ce;
        clr_id   = cid[ID_W-1:0];
        #1;
        elig = v;
        if (ce && cid < N_CH) elig[cid] = 1'b0;
        g = -1;
        for (int k = 1; k <= N_CH; k++) begin
            if (g < 0 && elig[(last_g + k) % N_CH]) g = (last_g + k) % N_CH;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("ch_ready", 64'(ch_ready), 64'(exp_ready));
        if (ce && cid < N_CH) begin
            hist_len[cid] = 0;
            hist[cid]     = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
            cnt_m[cid]    = 0;
`endif
        end
        exp_hit = 1'b0;
        if (g >= 0) begin
            hist[g] = {hist[g][2:0], b[g]};
            hist_len[g]++;
            if (hist_len[g] >= 4 && hist[g] == 4'b1011) begin
                exp_hit = 1'b1;
                sb.push_back('{edge_no: edge_cnt + 1, id: g});
`ifdef SEQ_DET_MATCH_CNT_EN
                if (cnt_m[g] < (1 << CNT_W) - 1) cnt_m[g]++;
`endif
            end
            last_g = g;
        end
        busy_exp = (g >= 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        for (int i = 0; i < N_CH; i++) cnt_exp[i*CNT_W +: CNT_W] = CNT_W'(cnt_m[i]);
`endif
    endtask

    task automatic drive_one(input int ch, input logic bv);
        logic [N_CH-1:0] v;
        logic [N_CH-1:0] b;
        int g;
        v = '0;
        b = '0;
        v[ch] = 1'b1;
        b[ch] = bv;
        drive(v, b, 1'b0, 0, g);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse, checks timing and id.
    initial begin
        exp_match_t e;
        forever begin
            @(posedge clk);
            #2;
            edge_cnt++;
            if (mon_en) begin
                if (match_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_match: got match_id=%0d at edge %0d, required no pulse",
                                 match_id, edge_cnt);
                    end else begin
                        e = sb.pop_front();
                        check("match_edge", 64'(edge_cnt), 64'(e.edge_no));
                        check("match_id", 64'(match_id), 64'(e.id));
                        last_id = e.id;
                    end
                end else begin
                    check("match_id_hold", 64'(match_id), 64'(last_id));
                    if (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                        e = sb.pop_front();
                        n_cmp++;
                        n_bad++;
                        $display("FAIL missed_match: got no pulse at edge %0d, required match_id=%0d",
                                 edge_cnt, e.id);
                    end
                end
                check("busy", 64'(busy), 64'(busy_exp));
`ifdef SEQ_DET_MATCH_CNT_EN
                check("match_cnt", 64'(match_cnt), 64'(cnt_exp));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int gc [N_CH];
        int q2 [$];
        int q3 [$];
        logic [N_CH-1:0] v;
        logic [N_CH-1:0] b;

        mon_en   = 1'b0;
        reset    = 1'b1;
        ch_valid = '0;
        ch_bit   = '0;
        clr_en   = 1'b0;
        clr_id   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_match_valid", 64'(match_valid), 64'(0));
        check("reset_match_id", 64'(match_id), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ch_ready", 64'(ch_ready), 64'(0));
        reset  = 1'b0;
        mon_en = 1'b1;

        // ch0 alone: 1,0,1,1 -> one pulse with id 0.
        drive_one(0, 1'b1); drive_one(0, 1'b0); drive_one(0, 1'b1); drive_one(0, 1'b1);
        // ch1 overlapping stream: two pulses.
        drive_one(1, 1'b1); drive_one(1, 1'b0); drive_one(1, 1'b1); drive_one(1, 1'b1);
        drive_one(1, 1'b0); drive_one(1, 1'b1); drive_one(1, 1'b1);

        // Fairness: all channels valid for 8 cycles.
        for (int i = 0; i < N_CH; i++) gc[i] = 0;
        for (int n = 0; n < 8; n++) begin
            drive('1, N_CH'($urandom), 1'b0, 0, g);
            if (g >= 0) gc[g]++;
        end
        for (int i = 0; i < N_CH; i++) check("fair_grants", 64'(gc[i]), 64'(2));

        // Interleaved ch2 / ch3 streams from cleared contexts.
        drive('0, '0, 1'b1, 2, g);
        drive('0, '0, 1'b1, 3, g);
        q2 = '{1, 0, 1};
        q3 = '{1, 0, 1, 1};
        for (int n = 0; n < 20 && (q2.size() > 0 || q3.size() > 0); n++) begin
            v = '0;
            b = '0;
            if (q2.size() > 0) begin v[2] = 1'b1; b[2] = q2[0][0]; end
            if (q3.size() > 0) begin v[3] = 1'b1; b[3] = q3[0][0]; end
            drive(v, b, 1'b0, 0, g);
            if (g == 2) void'(q2.pop_front());
            else if (g == 3) void'(q3.pop_front());
        end
        drive_one(2, 1'b1);

        // Clear beats a pending grant on ch0 sitting at S3.
        drive('0, '0, 1'b1, 0, g);
        drive_one(0, 1'b1); drive_one(0, 1'b0); drive_one(0, 1'b1);
        drive(4'b0011, 4'b0011, 1'b1, 0, g);
        drive_one(0, 1'b1);

        // Asynchronous reset while a ch1 pulse is on the output.
        drive('0, '0, 1'b1, 1, g);
        drive_one(1, 1'b1); drive_one(1, 1'b0); drive_one(1, 1'b1); drive_one(1, 1'b1);
        @(posedge clk);
        #3;
        check("pulse_before_reset", 64'(match_valid), 64'(exp_hit));
        mon_en   = 1'b0;
        ch_valid = '0;
        clr_en   = 1'b0;
        reset    = 1'b1;
        #1;
        check("reset_drops_pulse", 64'(match_valid), 64'(0));
        check("reset_drops_busy", 64'(busy), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        drive_one(1, 1'b1);
        drive_one(1, 1'b1);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 600; n++) begin
            drive(N_CH'($urandom), N_CH'($urandom), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, N_CH - 1)), g);
        end

        repeat (3) drive('0, '0, 1'b0, 0, g);
        @(posedge clk);
        #3;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
